// File: rtl/sum_display.sv
// Converts a 12-bit binary sum to BCD by sequential double-dabble and drives a
// 4-digit multiplexed common-anode 7-segment display with leading-zero blanking.
module sum_display #(
    parameter int IN_W        = 12,
    parameter int REFRESH_DIV = 27000,
    parameter int N_DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t            state_reg, state_next;
    logic [IN_W-1:0]   shreg_reg;
    logic [BCD_W-1:0]  scratch_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [BCD_W-1:0]  bcd_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [IDX_W-1:0]  scan_idx_reg;

    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_shift;
    logic [IN_W-1:0]   shreg_shift;
    logic [N_DIGITS-1:0] digit_blank;
    logic [3:0]        cur_digit;
    logic [6:0]        seg_pat;
    logic              digit_ok;

    // Add-3 correction on every nibble before the shift
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                            scratch_reg[4*gi +: 4] + 4'd3 :
                                            scratch_reg[4*gi +: 4];
        end
    endgenerate

    assign scratch_shift = {scratch_adj[BCD_W-2:0], shreg_reg[IN_W-1]};
    assign shreg_shift   = {shreg_reg[IN_W-2:0], 1'b0};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (bit_cnt_reg == CNT_W'(1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bcd is written on the final shift so it becomes visible together with done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            scratch_reg <= '0;
            bit_cnt_reg <= '0;
            bcd_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shreg_reg   <= value;
                        scratch_reg <= '0;
                        bit_cnt_reg <= CNT_W'(IN_W);
                    end
                end
                CONV: begin
                    scratch_reg <= scratch_shift;
                    shreg_reg   <= shreg_shift;
                    bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
                    if (bit_cnt_reg == CNT_W'(1))
                        bcd_reg <= scratch_shift;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == UPDATE);
    assign bcd  = bcd_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg      <= '0;
            scan_idx_reg <= '0;
        end else if (div_reg == DIV_W'(REFRESH_DIV - 1)) begin
            div_reg      <= '0;
            scan_idx_reg <= (scan_idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx_reg + IDX_W'(1);
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // A digit is blank when it and all higher digits are zero; the units digit always shows
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_units
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign digit_blank[gi] = (bcd_reg[BCD_W-1:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_digit = bcd_reg[4*scan_idx_reg +: 4];

    always_comb begin
        seg_pat  = 7'b1111111;
        digit_ok = 1'b1;
        case (cur_digit)
            4'd0:    seg_pat = 7'b1000000;
            4'd1:    seg_pat = 7'b1111001;
            4'd2:    seg_pat = 7'b0100100;
            4'd3:    seg_pat = 7'b0110000;
            4'd4:    seg_pat = 7'b0011001;
            4'd5:    seg_pat = 7'b0010010;
            4'd6:    seg_pat = 7'b0000010;
            4'd7:    seg_pat = 7'b1111000;
            4'd8:    seg_pat = 7'b0000000;
            4'd9:    seg_pat = 7'b0010000;
            default: digit_ok = 1'b0;
        endcase
    end

    always_comb begin
        seg = 7'b1111111;
        an  = '1;
        if (digit_ok && !digit_blank[scan_idx_reg]) begin
            seg              = seg_pat;
            an[scan_idx_reg] = 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_display.sv
// Directed bench for sum_display: a decimal-level model checked every cycle plus
// hand-computed expectations for latency, scan order, dropping and reset abort.
`timescale 1ns/1ps
module tb_sum_display;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] value;
    logic        load;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    sum_display #(.IN_W(12), .REFRESH_DIV(4), .N_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (decimal arithmetic) ----------------
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam int POW10 [4] = '{1, 10, 100, 1000};

    bit m_valid = 1'b0;
    int m_cnt   = 0;   // cycles left in the current conversion (1 = done cycle)
    int m_val   = 0;
    int m_num   = 0;   // number currently held in bcd
    int m_t     = 0;   // cycles since reset, drives the scan position

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_num   = 0;
            m_t     = 0;
        end else if (m_valid) begin
            m_t++;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 1) m_num = m_val;
            end else if (load) begin
                m_cnt = 13;
                m_val = int'(value);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int idx;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            idx = (m_t / 4) % 4;
            if (idx > 0 && m_num < POW10[idx]) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                exp_an      = 4'b1111;
                exp_an[idx] = 1'b0;
                exp_seg     = SEG_TAB[(m_num / POW10[idx]) % 10];
            end
            chk("model_busy", 32'(busy), 32'(m_cnt != 0));
            chk("model_done", 32'(done), 32'(m_cnt == 1));
            chk("model_bcd",  32'(bcd),  32'(to_bcd(m_num)));
            chk("model_an",   32'(an),   32'(exp_an));
            chk("model_seg",  32'(seg),  32'(exp_seg));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int j;
        int cnt;
        logic [3:0] prev_an;
        logic [3:0] exp_an_tab [4];
        logic [6:0] exp_seg_tab [4];

        reset = 1'b1; load = 1'b0; value = '0;
        tick(); tick();
        // 1. reset state
        chk("t1_an",   32'(an),   32'h0000000e);
        chk("t1_seg",  32'(seg),  32'h00000040);
        chk("t1_bcd",  32'(bcd),  32'h00000000);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_done", 32'(done), 32'h0);
        reset = 1'b0;
        tick();

        // 2. value 21: latency 13, slots 2 and 3 blank
        value = 12'd21; load = 1'b1;
        tick();
        load = 1'b0;
        chk("t2_busy", 32'(busy), 32'h1);
        j = 1;
        while (!done && j < 40) begin tick(); j++; end
        chk("t2_latency", 32'(j), 32'd13);
        chk("t2_bcd", 32'(bcd), 32'h00000021);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (an == 4'b1111) cnt++;
            tick();
        end
        chk("t2_blank_cycles", 32'(cnt), 32'd8);

        // 3. value 4095: full scan sequence
        value = 12'd4095; load = 1'b1;
        tick();
        load = 1'b0;
        j = 0;
        while (!done && j < 40) begin tick(); j++; end
        chk("t3_done_seen", 32'(done), 32'h1);
        chk("t3_bcd", 32'(bcd), 32'h00004095);
        exp_an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg_tab = '{7'b0010010, 7'b0010000, 7'b1000000, 7'b0011001};
        j = 0;
        prev_an = an;
        tick();
        while (!(an == 4'b1110 && prev_an != 4'b1110) && j < 40) begin
            prev_an = an; tick(); j++;
        end
        chk("t3_align", 32'(an), 32'h0000000e);
        for (int i = 0; i < 16; i++) begin
            chk("t3_an",  32'(an),  32'(exp_an_tab[i / 4]));
            chk("t3_seg", 32'(seg), 32'(exp_seg_tab[i / 4]));
            tick();
        end

        // 4. value 100, then 7 five cycles later (dropped)
        value = 12'd100; load = 1'b1;
        tick();
        load = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (done) cnt++;
            if (i == 5) begin value = 12'd7; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        load = 1'b0;
        chk("t4_done_count", 32'(cnt), 32'd1);
        chk("t4_bcd", 32'(bcd), 32'h00000100);
        chk("t4_idle", 32'(busy), 32'h0);

        // 5. value 999, reset on the 6th CONV cycle
        value = 12'd999; load = 1'b1;
        tick();
        load = 1'b0;
        cnt = 0;
        for (int i = 1; i < 6; i++) begin
            if (done) cnt++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_bcd",  32'(bcd),  32'h00000000);
        chk("t5_an",   32'(an),   32'h0000000e);
        chk("t5_seg",  32'(seg),  32'h00000040);
        chk("t5_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (done) cnt++;
            tick();
        end
        chk("t5_no_done", 32'(cnt), 32'd0);

        // 6. value 0 loaded in the cycle right after a done
        value = 12'd42; load = 1'b1;
        tick();
        load = 1'b0;
        j = 0;
        while (!done && j < 40) begin tick(); j++; end
        chk("t6_first_done", 32'(bcd), 32'h00000042);
        tick();
        value = 12'd0; load = 1'b1;
        tick();
        load = 1'b0;
        chk("t6_accepted", 32'(busy), 32'h1);
        j = 1;
        while (!done && j < 40) begin tick(); j++; end
        chk("t6_latency", 32'(j), 32'd13);
        chk("t6_bcd", 32'(bcd), 32'h00000000);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (an == 4'b1111) cnt++;
            else begin
                chk("t6_an",  32'(an),  32'h0000000e);
                chk("t6_seg", 32'(seg), 32'h00000040);
            end
            tick();
        end
        chk("t6_blank_cycles", 32'(cnt), 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
